// File: rtl/rc4_key_search_ctrl_if.sv
// Bundle between the RC4 key-search sequencer and its sub-blocks, S RAM and host.
// master = the sequencer; slave = the surrounding datapath/host.
interface rc4_key_search_ctrl_if #(
  parameter int unsigned KEY_W = 24
) ();
  // start/finish: *_start is a 1-cycle pulse; *_finish may be a pulse or a level and
  // counts only while the sequencer sits in the matching *_WAIT state.
  logic             start;
  logic             init_start;
  logic             init_finish;
  logic             ksa_start;
  logic             ksa_finish;
  logic             prga_start;
  logic             prga_finish;
  logic             msg_ok;
  logic [7:0]       init_addr;
  logic [7:0]       init_data;
  logic             init_wen;
  logic [7:0]       ksa_addr;
  logic [7:0]       ksa_data;
  logic             ksa_wen;
  logic [7:0]       prga_addr;
  logic [7:0]       prga_data;
  logic             prga_wen;
  logic [7:0]       s_address;
  logic [7:0]       s_data;
  logic             s_wen;
  logic [1:0]       memory_sel;
  logic [KEY_W-1:0] secret_key;
  logic             busy;
  logic             found;
  logic             fail;
  logic             timeout;
  logic [3:0]       state_dbg;

  modport master (
    input  start, init_finish, ksa_finish, prga_finish, msg_ok,
    input  init_addr, init_data, init_wen,
    input  ksa_addr, ksa_data, ksa_wen,
    input  prga_addr, prga_data, prga_wen,
    output init_start, ksa_start, prga_start,
    output s_address, s_data, s_wen, memory_sel,
    output secret_key, busy, found, fail, timeout, state_dbg
  );

  modport slave (
    output start, init_finish, ksa_finish, prga_finish, msg_ok,
    output init_addr, init_data, init_wen,
    output ksa_addr, ksa_data, ksa_wen,
    output prga_addr, prga_data, prga_wen,
    input  init_start, ksa_start, prga_start,
    input  s_address, s_data, s_wen, memory_sel,
    input  secret_key, busy, found, fail, timeout, state_dbg
  );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// RC4 key-search sequencer: per candidate key runs init -> KSA -> PRGA, arbitrates the
// single-port S RAM to the active sub-block, then checks the plaintext and reports or advances.
module rc4_key_search_ctrl #(
  parameter int unsigned      KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_MAX   = 24'h3FFFFF,
  parameter logic [15:0]      TIMEOUT   = 16'd2048
) (
  input logic                   clk,
  input logic                   reset,
  rc4_key_search_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INIT_GO   = 4'd1,
    ST_INIT_WAIT = 4'd2,
    ST_KSA_GO    = 4'd3,
    ST_KSA_WAIT  = 4'd4,
    ST_PRGA_GO   = 4'd5,
    ST_PRGA_WAIT = 4'd6,
    ST_CHECK     = 4'd7,
    ST_NEXT_KEY  = 4'd8,
    ST_FOUND     = 4'd9,
    ST_FAIL      = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [15:0]      wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic             wd_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      key_q     <= KEY_START;
      wd_q      <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  // wd_q counts cycles already spent in the current WAIT state, so the limit is hit
  // on the TIMEOUT-th cycle there.
  assign wd_expired = (TIMEOUT != 16'd0) && (wd_q == (TIMEOUT - 16'd1));

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          key_d   = KEY_START;
          state_d = ST_INIT_GO;
        end
      end
      ST_INIT_GO: begin
        wd_d    = 16'd0;
        state_d = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        wd_d = wd_q + 16'd1;
        if (bus.init_finish) begin
          state_d = ST_KSA_GO;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_FAIL;
        end
      end
      ST_KSA_GO: begin
        wd_d    = 16'd0;
        state_d = ST_KSA_WAIT;
      end
      ST_KSA_WAIT: begin
        wd_d = wd_q + 16'd1;
        if (bus.ksa_finish) begin
          state_d = ST_PRGA_GO;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_FAIL;
        end
      end
      ST_PRGA_GO: begin
        wd_d    = 16'd0;
        state_d = ST_PRGA_WAIT;
      end
      ST_PRGA_WAIT: begin
        wd_d = wd_q + 16'd1;
        if (bus.prga_finish) begin
          state_d = ST_CHECK;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_FAIL;
        end
      end
      ST_CHECK: begin
        if (bus.msg_ok) begin
          state_d = ST_FOUND;
        end else if (key_q == KEY_MAX) begin
          state_d = ST_FAIL;
        end else begin
          state_d = ST_NEXT_KEY;
        end
      end
      ST_NEXT_KEY: begin
        key_d   = key_q + KEY_W'(1);
        state_d = ST_INIT_GO;
      end
      ST_FOUND, ST_FAIL: begin
        if (bus.start) begin
          timeout_d = 1'b0;
          key_d     = KEY_START;
          state_d   = ST_INIT_GO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.init_start = (state_q == ST_INIT_GO);
    bus.ksa_start  = (state_q == ST_KSA_GO);
    bus.prga_start = (state_q == ST_PRGA_GO);
    bus.busy       = (state_q != ST_IDLE) && (state_q != ST_FOUND) && (state_q != ST_FAIL);
    bus.found      = (state_q == ST_FOUND);
    bus.fail       = (state_q == ST_FAIL);
    bus.timeout    = timeout_q;
    bus.secret_key = key_q;
    bus.state_dbg  = state_q;
  end

  // S RAM grant follows the registered state directly, so the owner's request passes through
  // with no added latency; ungranted requests never reach the RAM.
  always_comb begin
    bus.memory_sel = 2'b00;
    bus.s_address  = 8'd0;
    bus.s_data     = 8'd0;
    bus.s_wen      = 1'b0;
    case (state_q)
      ST_INIT_GO, ST_INIT_WAIT: begin
        bus.memory_sel = 2'b01;
        bus.s_address  = bus.init_addr;
        bus.s_data     = bus.init_data;
        bus.s_wen      = bus.init_wen;
      end
      ST_KSA_GO, ST_KSA_WAIT: begin
        bus.memory_sel = 2'b10;
        bus.s_address  = bus.ksa_addr;
        bus.s_data     = bus.ksa_data;
        bus.s_wen      = bus.ksa_wen;
      end
      ST_PRGA_GO, ST_PRGA_WAIT: begin
        bus.memory_sel = 2'b11;
        bus.s_address  = bus.prga_addr;
        bus.s_data     = bus.prga_data;
        bus.s_wen      = bus.prga_wen;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl: instance A (KEY_START=0, TIMEOUT=16) covers the main flow,
// arbitration, stray finishes, watchdog and async reset; instance B covers the end-of-range FAIL.
module tb_rc4_key_search_ctrl;

  localparam logic [3:0] S_IDLE = 4'd0, S_INIT_GO = 4'd1, S_INIT_WAIT = 4'd2, S_KSA_GO = 4'd3,
                         S_KSA_WAIT = 4'd4, S_PRGA_GO = 4'd5, S_PRGA_WAIT = 4'd6, S_CHECK = 4'd7,
                         S_FOUND = 4'd9, S_FAIL = 4'd10;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad = 0;

  rc4_key_search_ctrl_if #(.KEY_W(24)) ifa ();
  rc4_key_search_ctrl_if #(.KEY_W(24)) ifb ();

  rc4_key_search_ctrl #(.KEY_W(24), .KEY_START(24'h000000), .KEY_MAX(24'h3FFFFF), .TIMEOUT(16'd16))
    dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  rc4_key_search_ctrl #(.KEY_W(24), .KEY_START(24'h3FFFFE), .KEY_MAX(24'h3FFFFF), .TIMEOUT(16'd2048))
    dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  initial forever #5 clk = ~clk;

  // ---------------- stub sub-blocks ----------------
  bit          auto_a = 1'b1;
  bit          prga_hold_a = 1'b0;
  bit          ok_all_a = 1'b1;
  logic [23:0] ok_key_a = 24'hFFFFFF;
  logic        man_init = 1'b0, man_ksa = 1'b0, man_prga = 1'b0;
  logic        sa_init = 1'b0, sa_ksa = 1'b0, sa_prga = 1'b0;
  logic        sb_init = 1'b0, sb_ksa = 1'b0, sb_prga = 1'b0;
  int          ca_init = 0, ca_ksa = 0, ca_prga = 0;
  int          cb_init = 0, cb_ksa = 0, cb_prga = 0;
  int          pulses_a = 0, pulses_b = 0, multi_start = 0;

  assign ifa.init_finish = auto_a ? sa_init : man_init;
  assign ifa.ksa_finish  = auto_a ? sa_ksa  : man_ksa;
  assign ifa.prga_finish = auto_a ? sa_prga : man_prga;
  assign ifa.msg_ok      = ok_all_a | (ifa.secret_key == ok_key_a);
  assign ifb.init_finish = sb_init;
  assign ifb.ksa_finish  = sb_ksa;
  assign ifb.prga_finish = sb_prga;
  assign ifb.msg_ok      = 1'b0;

  // A stub block raises finish for one cycle, five cycles after seeing its start pulse.
  task automatic stub_step(input logic go, input bit hold, input int cnt_i,
                           output int cnt_o, output logic fin);
    fin = 1'b0;
    if (go) cnt_o = 5;
    else if (cnt_i > 1) cnt_o = cnt_i - 1;
    else begin
      cnt_o = 0;
      fin   = (cnt_i == 1) && !hold;
    end
  endtask

  initial forever begin
    @(negedge clk);
    stub_step(ifa.init_start, 1'b0, ca_init, ca_init, sa_init);
    stub_step(ifa.ksa_start, 1'b0, ca_ksa, ca_ksa, sa_ksa);
    stub_step(ifa.prga_start, prga_hold_a, ca_prga, ca_prga, sa_prga);
    stub_step(ifb.init_start, 1'b0, cb_init, cb_init, sb_init);
    stub_step(ifb.ksa_start, 1'b0, cb_ksa, cb_ksa, sb_ksa);
    stub_step(ifb.prga_start, 1'b0, cb_prga, cb_prga, sb_prga);
  end

  initial forever begin
    @(negedge clk);
    if (ifa.init_start) pulses_a++;
    if (ifb.init_start) pulses_b++;
    if ((32'(ifa.init_start) + 32'(ifa.ksa_start) + 32'(ifa.prga_start)) > 1) multi_start++;
    if ((32'(ifb.init_start) + 32'(ifb.ksa_start) + 32'(ifb.prga_start)) > 1) multi_start++;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a(input string tag, input logic [3:0] st, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (ifa.state_dbg == st) break;
      @(negedge clk);
    end
    chk(tag, 32'(ifa.state_dbg), 32'(st));
  endtask

  task automatic wait_b(input string tag, input logic [3:0] st, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (ifb.state_dbg == st) break;
      @(negedge clk);
    end
    chk(tag, 32'(ifb.state_dbg), 32'(st));
  endtask

  task automatic pulse_start_a();
    @(negedge clk) ifa.start = 1'b1;
    @(negedge clk) ifa.start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0, n;
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.start = 1'b0; ifb.start = 1'b0;
    ifa.init_addr = 8'h00; ifa.init_data = 8'h00; ifa.init_wen = 1'b0;
    ifa.ksa_addr  = 8'h00; ifa.ksa_data  = 8'h00; ifa.ksa_wen  = 1'b0;
    ifa.prga_addr = 8'h00; ifa.prga_data = 8'h00; ifa.prga_wen = 1'b0;
    ifb.init_addr = 8'h00; ifb.init_data = 8'h00; ifb.init_wen = 1'b0;
    ifb.ksa_addr  = 8'h00; ifb.ksa_data  = 8'h00; ifb.ksa_wen  = 1'b0;
    ifb.prga_addr = 8'h00; ifb.prga_data = 8'h00; ifb.prga_wen = 1'b0;
    repeat (2) @(negedge clk);

    // 1: reset values, then a single successful trial with start pulses in order
    chk("rst_state", 32'(ifa.state_dbg), 32'(S_IDLE));
    chk("rst_key", 32'(ifa.secret_key), 32'h0);
    chk("rst_starts", {29'd0, ifa.init_start, ifa.ksa_start, ifa.prga_start}, 32'h0);
    chk("rst_flags", {28'd0, ifa.busy, ifa.found, ifa.fail, ifa.timeout}, 32'h0);
    chk("rst_mem", {15'd0, ifa.s_wen, ifa.s_address, ifa.s_data}, 32'h0);
    chk("rst_sel", 32'(ifa.memory_sel), 32'h0);
    chk("rst_key_b", 32'(ifb.secret_key), 32'h3FFFFE);
    rst_a = 1'b0;
    pulse_start_a();
    chk("t1_init_go", 32'(ifa.state_dbg), 32'(S_INIT_GO));
    chk("t1_init_start", {29'd0, ifa.init_start, ifa.ksa_start, ifa.prga_start}, 32'h4);
    chk("t1_busy", 32'(ifa.busy), 32'h1);
    @(negedge clk);
    chk("t1_init_pulse_end", {29'd0, ifa.init_start, ifa.ksa_start, ifa.prga_start}, 32'h0);
    wait_a("t1_reach_ksa_go", S_KSA_GO, 20);
    chk("t1_ksa_start", {29'd0, ifa.init_start, ifa.ksa_start, ifa.prga_start}, 32'h2);
    @(negedge clk);
    chk("t1_ksa_pulse_end", 32'(ifa.ksa_start), 32'h0);
    wait_a("t1_reach_prga_go", S_PRGA_GO, 20);
    chk("t1_prga_start", {29'd0, ifa.init_start, ifa.ksa_start, ifa.prga_start}, 32'h1);
    wait_a("t1_reach_found", S_FOUND, 20);
    chk("t1_flags", {28'd0, ifa.busy, ifa.found, ifa.fail, ifa.timeout}, 32'h4);
    chk("t1_key", 32'(ifa.secret_key), 32'h0);

    // 2: only key 3 decrypts cleanly -> four trials
    ok_all_a = 1'b0; ok_key_a = 24'h000003;
    p0 = pulses_a;
    pulse_start_a();
    chk("t2_restart_state", 32'(ifa.state_dbg), 32'(S_INIT_GO));
    chk("t2_flags_cleared", {28'd0, ifa.busy, ifa.found, ifa.fail, ifa.timeout}, 32'h8);
    wait_a("t2_reach_found", S_FOUND, 400);
    chk("t2_key", 32'(ifa.secret_key), 32'h3);
    chk("t2_flags", {28'd0, ifa.busy, ifa.found, ifa.fail, ifa.timeout}, 32'h4);
    chk("t2_init_pulses", 32'(pulses_a - p0), 32'd4);

    // 4: arbitration with all three requesters writing
    ok_all_a = 1'b1;
    ifa.init_addr = 8'h11; ifa.init_data = 8'hA1; ifa.init_wen = 1'b1;
    ifa.ksa_addr  = 8'h22; ifa.ksa_data  = 8'hB2; ifa.ksa_wen  = 1'b1;
    ifa.prga_addr = 8'h33; ifa.prga_data = 8'hC3; ifa.prga_wen = 1'b1;
    pulse_start_a();
    chk("t4_init_bus", {13'd0, ifa.memory_sel, ifa.s_wen, ifa.s_address, ifa.s_data}, 32'h311A1);
    wait_a("t4_reach_ksa_wait", S_KSA_WAIT, 20);
    chk("t4_ksa_bus", {13'd0, ifa.memory_sel, ifa.s_wen, ifa.s_address, ifa.s_data}, 32'h522B2);
    wait_a("t4_reach_prga_wait", S_PRGA_WAIT, 20);
    chk("t4_prga_bus", {13'd0, ifa.memory_sel, ifa.s_wen, ifa.s_address, ifa.s_data}, 32'h733C3);
    wait_a("t4_reach_check", S_CHECK, 20);
    chk("t4_check_bus", {13'd0, ifa.memory_sel, ifa.s_wen, ifa.s_address, ifa.s_data}, 32'h0);
    wait_a("t4_reach_found", S_FOUND, 5);
    chk("t4_found_bus", {13'd0, ifa.memory_sel, ifa.s_wen, ifa.s_address, ifa.s_data}, 32'h0);

    // 5: stray finishes ignored; held init_finish does not satisfy KSA_WAIT
    auto_a = 1'b0;
    pulse_start_a();
    @(negedge clk);
    chk("t5_init_wait", 32'(ifa.state_dbg), 32'(S_INIT_WAIT));
    man_ksa = 1'b1; man_prga = 1'b1;
    @(negedge clk);
    chk("t5_stray_ignored", 32'(ifa.state_dbg), 32'(S_INIT_WAIT));
    man_ksa = 1'b0; man_prga = 1'b0; man_init = 1'b1;
    @(negedge clk);
    chk("t5_ksa_go", 32'(ifa.state_dbg), 32'(S_KSA_GO));
    repeat (4) @(negedge clk);
    chk("t5_ksa_still_waits", 32'(ifa.state_dbg), 32'(S_KSA_WAIT));
    man_ksa = 1'b1;
    @(negedge clk);
    chk("t5_prga_go", 32'(ifa.state_dbg), 32'(S_PRGA_GO));
    man_ksa = 1'b0; man_init = 1'b0; man_prga = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_check", 32'(ifa.state_dbg), 32'(S_CHECK));
    man_prga = 1'b0;
    @(negedge clk);
    chk("t5_found", 32'(ifa.state_dbg), 32'(S_FOUND));
    auto_a = 1'b1;

    // 6: watchdog on PRGA_WAIT, then asynchronous reset during KSA_WAIT
    prga_hold_a = 1'b1;
    pulse_start_a();
    wait_a("t6_reach_prga_wait", S_PRGA_WAIT, 30);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifa.state_dbg != S_PRGA_WAIT) break;
      n++;
    end
    chk("t6_wait_cycles", 32'(n), 32'd16);
    chk("t6_state_fail", 32'(ifa.state_dbg), 32'(S_FAIL));
    chk("t6_flags", {28'd0, ifa.busy, ifa.found, ifa.fail, ifa.timeout}, 32'h3);
    chk("t6_key", 32'(ifa.secret_key), 32'h0);
    prga_hold_a = 1'b0;
    pulse_start_a();
    chk("t6_restart_flags", {28'd0, ifa.busy, ifa.found, ifa.fail, ifa.timeout}, 32'h8);
    wait_a("t6_reach_ksa_wait", S_KSA_WAIT, 20);
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("t6_rst_state", 32'(ifa.state_dbg), 32'(S_IDLE));
    chk("t6_rst_starts", {29'd0, ifa.init_start, ifa.ksa_start, ifa.prga_start}, 32'h0);
    chk("t6_rst_bus", {13'd0, ifa.memory_sel, ifa.s_wen, ifa.s_address, ifa.s_data}, 32'h0);
    chk("t6_rst_flags", {28'd0, ifa.busy, ifa.found, ifa.fail, ifa.timeout}, 32'h0);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_idle_after_rst", 32'(ifa.state_dbg), 32'(S_IDLE));

    // 3: instance B starts one below KEY_MAX, msg_ok never set -> two trials then FAIL
    rst_b = 1'b0;
    p0 = pulses_b;
    @(negedge clk) ifb.start = 1'b1;
    @(negedge clk) ifb.start = 1'b0;
    chk("t3_first_key", 32'(ifb.secret_key), 32'h3FFFFE);
    wait_b("t3_reach_fail", S_FAIL, 300);
    chk("t3_flags", {28'd0, ifb.busy, ifb.found, ifb.fail, ifb.timeout}, 32'h2);
    chk("t3_key", 32'(ifb.secret_key), 32'h3FFFFF);
    chk("t3_init_pulses", 32'(pulses_b - p0), 32'd2);
    repeat (3) @(negedge clk);
    chk("t3_fail_holds", 32'(ifb.state_dbg), 32'(S_FAIL));

    chk("one_start_at_a_time", 32'(multi_start), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
